// File: rtl/mult8_rr_sched.sv
// Round-robin scheduler sharing one sequential 8x8 multiplier core among NREQ requesters.
// Zero operands can bypass the core; a wait counter aborts when the core never reports done.
module mult8_rr_sched #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT     = 32,
  parameter int ZERO_BYPASS = 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [8*NREQ-1:0]       req_a,
  input  logic [8*NREQ-1:0]       req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [15:0]             rsp_product,
  output logic                    rsp_err,
  output logic                    mul_start,
  output logic [7:0]              mul_a,
  output logic [7:0]              mul_b,
  input  logic                    mul_done,
  input  logic [15:0]             mul_product,
  output logic                    busy
);
  localparam int DATA_W = 8;
  localparam int IDW    = $clog2(NREQ);
  localparam int CNT_W  = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  logic [1:0]        state;
  logic [IDW-1:0]    rr_ptr;
  logic [IDW-1:0]    grant_idx;
  logic              found;
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;

  function automatic logic is_bypass(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
    return (ZERO_BYPASS != 0) && ((a == '0) || (b == '0));
  endfunction

  // Rotating priority search starting at rr_ptr.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if ((state == IDLE) && !wb_rst_i && found)
      req_ready[grant_idx] = 1'b1;
  end

  assign sel_a     = req_a[DATA_W*int'(grant_idx) +: DATA_W];
  assign sel_b     = req_b[DATA_W*int'(grant_idx) +: DATA_W];
  assign rsp_valid = (state == RESP);
  assign mul_start = (state == ISSUE);
  assign busy      = (state != IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      wait_cnt    <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      rsp_id      <= '0;
      rsp_product <= '0;
      rsp_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            rsp_id <= grant_idx;
            if (is_bypass(sel_a, sel_b)) begin
              rsp_product <= '0;
              rsp_err     <= 1'b0;
              state       <= RESP;
            end else begin
              // Core operands only change when a new multiply is actually issued.
              mul_a <= sel_a;
              mul_b <= sel_b;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (mul_done) begin
            rsp_product <= mul_product;
            rsp_err     <= 1'b0;
            state       <= RESP;
          end else if (wait_cnt == CNT_LAST) begin
            rsp_product <= '0;
            rsp_err     <= 1'b1;
            state       <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rr_ptr <= IDW'((int'(rsp_id) + 1) % NREQ);
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult8_rr_sched.sv
// Bench for mult8_rr_sched: directed scenarios plus randomized traffic against a round-robin model.
// A behavioural core answers each mul_start after a programmable number of cycles (0 = never).
module tb_mult8_rr_sched;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [3:0]  req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic        rsp_valid, rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_product;
  logic        rsp_err, mul_start, busy;
  logic [7:0]  mul_a, mul_b;
  logic        mul_done = 1'b0;
  logic [15:0] mul_product = 16'd0;

  logic [3:0]  b_req_valid, b_req_ready;
  logic [31:0] b_req_a, b_req_b;
  logic        b_rsp_valid, b_rsp_ready;
  logic [1:0]  b_rsp_id;
  logic [15:0] b_rsp_product;
  logic        b_rsp_err, b_mul_start, b_busy;
  logic [7:0]  b_mul_a, b_mul_b;
  logic        b_mul_done = 1'b0;
  logic [15:0] b_mul_product = 16'd0;

  int checks = 0;
  int failures = 0;
  int core_lat = 0;
  int core_cnt = 0;
  int starts = 0;
  int b_starts = 0;
  logic        b_pend = 1'b0;
  logic [7:0]  start_a = 8'd0, start_b = 8'd0;
  logic [15:0] core_prod = 16'd0;

  mult8_rr_sched #(.NREQ(4), .TIMEOUT(32), .ZERO_BYPASS(1)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_product(rsp_product), .rsp_err(rsp_err),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_product(mul_product), .busy(busy)
  );

  mult8_rr_sched #(.NREQ(4), .TIMEOUT(32), .ZERO_BYPASS(0)) dut_nobyp (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_a(b_req_a), .req_b(b_req_b),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_id(b_rsp_id),
    .rsp_product(b_rsp_product), .rsp_err(b_rsp_err),
    .mul_start(b_mul_start), .mul_a(b_mul_a), .mul_b(b_mul_b),
    .mul_done(b_mul_done), .mul_product(b_mul_product), .busy(b_busy)
  );

  // Core model: done arrives core_lat cycles after the start cycle; unaffected by DUT reset.
  always @(posedge clk) begin
    #1;
    mul_done = 1'b0;
    if (core_cnt > 0) begin
      core_cnt--;
      if (core_cnt == 0) begin
        mul_done    = 1'b1;
        mul_product = core_prod;
      end
    end
    if (mul_start) begin
      starts++;
      start_a   = mul_a;
      start_b   = mul_b;
      core_prod = 16'(mul_a) * 16'(mul_b);
      core_cnt  = core_lat;
    end
  end

  // Fixed one-cycle core for the non-bypass instance.
  always @(posedge clk) begin
    #1;
    b_mul_done    = b_pend;
    b_mul_product = 16'(b_mul_a) * 16'(b_mul_b);
    b_pend        = b_mul_start;
    if (b_mul_start) b_starts++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] outs();
    return {22'd0, req_ready, rsp_valid, busy, mul_start, mul_a, mul_b, rsp_product, rsp_id, rsp_err};
  endfunction

  task automatic do_reset(input string tag);
    rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; b_req_valid = '0; b_rsp_ready = 1'b0;
    @(posedge clk); #1;
    check(tag, outs(), 64'd0);
    rst = 1'b0;
  endtask

  task automatic wait_rsp(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 200);
  endtask

  // One transaction: present vmask, check the grant, then latency/response, then acknowledge.
  task automatic run_txn(input string tag, input logic [3:0] vmask, input bit keep,
                         input int lat, input int hold, input int exp_id, input int exp_prod,
                         input bit exp_err, input int exp_lat, input int exp_starts);
    int s0, n;
    s0 = starts;
    core_lat = lat;
    req_valid = vmask;
    @(negedge clk);
    check({tag, "_ready"}, 64'(req_ready), 64'(1 << exp_id));
    @(posedge clk); #1;
    if (!keep) req_valid = '0;
    wait_rsp(n);
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_id"}, 64'(rsp_id), 64'(exp_id));
    check({tag, "_product"}, 64'(rsp_product), 64'(exp_prod));
    check({tag, "_err"}, 64'(rsp_err), 64'(exp_err));
    check({tag, "_starts"}, 64'(starts - s0), 64'(exp_starts));
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    int n, mp, id, lat;
    logic [3:0] mask;
    logic [7:0] ra [4];
    logic [7:0] rb [4];
    bit byp;

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    b_req_valid = '0; b_req_a = '0; b_req_b = '0; b_rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    do_reset("reset");

    // Single request from requester 2, core done 8 cycles after start.
    req_a = 32'(13) << 16; req_b = 32'(11) << 16;
    run_txn("single", 4'b0100, 0, 8, 0, 2, 143, 0, 10, 1);
    check("single_mul_a", 64'(start_a), 64'd13);
    check("single_mul_b", 64'(start_b), 64'd11);

    // All requesters continuously valid, a=b=i+1.
    do_reset("reset_rr");
    req_a = {8'd4, 8'd3, 8'd2, 8'd1}; req_b = {8'd4, 8'd3, 8'd2, 8'd1};
    for (int i = 0; i < 5; i++)
      run_txn("rr", 4'b1111, 1, 3, 0, i % 4, (i % 4 + 1) * (i % 4 + 1), 0, 5, 1);
    req_valid = '0;
    do_reset("reset_rr2");
    run_txn("rr_pair1", 4'b1010, 1, 2, 0, 1, 4, 0, 4, 1);
    run_txn("rr_pair3", 4'b1010, 1, 2, 0, 3, 16, 0, 4, 1);
    req_valid = '0;

    // Zero operand skips the core.
    req_a = 32'd0; req_b = 32'd200;
    run_txn("bypass", 4'b0001, 0, 3, 0, 0, 0, 0, 1, 0);

    // Same request on the instance without bypass goes through the core.
    b_req_a = 32'd0; b_req_b = 32'd200; b_req_valid = 4'b0001;
    @(negedge clk);
    check("nobyp_ready", 64'(b_req_ready), 64'd1);
    @(posedge clk); #1;
    b_req_valid = '0;
    n = 0;
    do begin @(negedge clk); n++; end while (!b_rsp_valid && n < 50);
    check("nobyp_latency", 64'(n), 64'd3);
    check("nobyp_starts", 64'(b_starts), 64'd1);
    check("nobyp_rsp", {45'd0, b_rsp_id, b_rsp_err, b_rsp_product}, 64'd0);
    b_rsp_ready = 1'b1;
    @(posedge clk); #1;
    b_rsp_ready = 1'b0;
    @(negedge clk);
    check("nobyp_idle", {62'd0, b_busy, b_rsp_valid}, 64'd0);
    @(posedge clk); #1;

    // Timeout, done in the final WAIT cycle, and done one cycle too late.
    req_a = 32'(5) << 8; req_b = 32'(6) << 8;
    run_txn("timeout", 4'b0010, 0, 0, 0, 1, 0, 1, 34, 1);
    run_txn("done_last", 4'b0010, 0, 32, 0, 1, 30, 0, 34, 1);
    run_txn("done_late", 4'b0010, 0, 33, 0, 1, 0, 1, 34, 1);

    // Backpressure with requester 0 also waiting.
    req_a = {8'd255, 16'd0, 8'd3}; req_b = {8'd255, 16'd0, 8'd5};
    core_lat = 2;
    req_valid = 4'b1001;
    @(negedge clk);
    check("bp_ready", 64'(req_ready), 64'b1000);
    @(posedge clk); #1;
    wait_rsp(n);
    for (int i = 0; i < 20; i++) begin
      check("bp_hold", {43'd0, rsp_valid, rsp_product, req_ready}, {43'd0, 1'b1, 16'd65025, 4'b0000});
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_next_grant", 64'(req_ready), 64'b0001);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp(n);
    check("bp_second", {46'd0, rsp_id, rsp_product}, {46'd0, 2'd0, 16'd15});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;

    // Reset during WAIT; the core's done pulse arrives afterwards.
    req_a = 32'(9) << 16; req_b = 32'(9) << 16;
    core_lat = 10;
    req_valid = 4'b0100;
    @(negedge clk);
    check("rstwait_ready", 64'(req_ready), 64'b0100);
    @(posedge clk); #1;
    req_valid = '0;
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("rstwait_quiet", outs(), 64'd0);
    end
    @(posedge clk); #1;
    req_a = {8'd0, 8'd9, 8'd0, 8'd2}; req_b = {8'd0, 8'd9, 8'd0, 8'd7};
    run_txn("post_reset", 4'b0101, 0, 1, 0, 0, 14, 0, 3, 1);

    // Randomized traffic against the rotating-priority rule.
    do_reset("reset_rand");
    mp = 0;
    for (int t = 0; t < 40; t++) begin
      mask = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        ra[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
        rb[i] = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      end
      req_a = {ra[3], ra[2], ra[1], ra[0]};
      req_b = {rb[3], rb[2], rb[1], rb[0]};
      id = -1;
      for (int k = 0; k < 4; k++)
        if (id < 0 && mask[(mp + k) % 4]) id = (mp + k) % 4;
      byp = (ra[id] == 8'd0) || (rb[id] == 8'd0);
      lat = int'($urandom_range(1, 6));
      run_txn("rand", mask, 0, lat, int'($urandom_range(0, 3)), id,
              int'(ra[id]) * int'(rb[id]), 0, byp ? 1 : lat + 2, byp ? 0 : 1);
      mp = (id + 1) % 4;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mult8_rr_sched.md
Name: mult8_rr_sched

Overview:
- Round-robin scheduler that shares one sequential 8x8 multiplier core among NREQ requesters.
- Accepts operand pairs over per-requester valid/ready handshakes and issues a one-cycle start pulse to the core.
- Waits for the core's done pulse, with a timeout guard, and returns a 16-bit product tagged with the requester ID.
- Sits inside the user project between the io/LA-facing logic and the multiplier core.

Parameters:
- NREQ, 4: number of requesters (2..8).
- TIMEOUT, 32: maximum cycles to wait for mul_done after start before aborting (>=2).
- ZERO_BYPASS, 1: when 1, an operand pair containing a zero skips the core and returns 0.

Ports:
- wb_clk_i  input  1  single clock; all logic on the rising edge.
- wb_rst_i  input  1  synchronous reset, active-high.
- req_valid  input  NREQ  per-requester operand valid.
- req_ready  output  NREQ  per-requester accept; one-hot or zero.
- req_a  input  8*NREQ  multiplicand; requester i uses bits [8i+7:8i].
- req_b  input  8*NREQ  multiplier; same packing as req_a.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  $clog2(NREQ)  requester index of the response.
- rsp_product  output  16  unsigned product.
- rsp_err  output  1  1 = timeout abort; rsp_product is 0.
- mul_start  output  1  one-cycle start pulse to the core.
- mul_a  output  8  operand A to the core; held stable from start until done.
- mul_b  output  8  operand B to the core; held stable from start until done.
- mul_done  input  1  one-cycle completion pulse from the core.
- mul_product  input  16  core result; valid in the cycle mul_done=1.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset: wb_rst_i=1 at a clock edge forces state IDLE and rr_ptr=0. All outputs are 0 after that edge, including mul_a, mul_b, rsp_*, req_ready and busy.
- Reset mid-operation aborts the transaction with no response. A late mul_done arriving after reset is ignored.
- State IDLE:
  - req_ready is combinational. It is one-hot on the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
  - On the handshake edge: latch a, b and the grant index g.
  - If ZERO_BYPASS=1 and (a==0 or b==0): go to RESP with product 0 and err 0.
  - Otherwise go to ISSUE.
- State ISSUE: mul_start=1 for exactly one cycle with latched mul_a and mul_b. Clear wait_cnt and go to WAIT. A mul_done in this cycle is ignored.
- State WAIT:
  - wait_cnt increments each cycle.
  - On mul_done=1: latch mul_product, err=0, go to RESP.
  - Else if wait_cnt==TIMEOUT-1: product=0, err=1, go to RESP.
  - If mul_done and the timeout coincide in the same cycle, done wins (err=0).
- State RESP:
  - rsp_valid=1; rsp_id, rsp_product and rsp_err stay stable until rsp_ready=1.
  - On the rsp_valid & rsp_ready edge: rr_ptr=(g+1) mod NREQ, go to IDLE.
  - mul_done in RESP is ignored.
- req_ready=0 in every state except IDLE. The next grant can occur in the cycle after the response handshake.
- Latency, valid request to rsp_valid, core path: 1 (IDLE) + 1 (ISSUE) + core cycles + 1.
- Latency, bypass path: rsp_valid in the cycle after the request handshake.
- Fairness: a continuously asserted requester waits at most NREQ-1 other transactions.
- A requester dropping req_valid before it is granted is legal; it is simply not served.
- mul_a and mul_b hold their last issued values when idle.

Test Plan:
- Single request: requester 2 sends a=13, b=11; core done 8 cycles after start. Expect:
  - exactly one mul_start with mul_a=13, mul_b=11;
  - rsp_product=143, rsp_id=2, rsp_err=0;
  - rsp_valid rises 10 cycles after the request handshake.
- Round robin: all 4 requesters hold valid continuously with a=b=i+1.
  - Expect grants 0,1,2,3,0, products 1,4,9,16.
  - After reset with only req 3 and req 1 valid, expect 1 then 3.
- Zero bypass: req 0 sends a=0, b=200.
  - Expect no mul_start; rsp_valid the next cycle with product 0, err 0.
  - With ZERO_BYPASS=0, expect mul_start and the core result is returned.
- Timeout: core never asserts done, TIMEOUT=32. Expect rsp_err=1 and product 0, 33 cycles after the mul_start cycle (ISSUE + 32 WAIT cycles). A mul_done in exactly the final WAIT cycle gives err=0 instead.
- Backpressure: hold rsp_ready=0 for 20 cycles with a=255, b=255.
  - Expect rsp_product=65025 stable and req_ready=0 throughout.
  - On release, expect the next grant the following cycle.
- Reset mid-WAIT: assert wb_rst_i for 1 cycle, then pulse mul_done.
  - Expect no rsp_valid and all outputs 0.
  - Expect rr_ptr=0, so req 0 is granted first afterwards.
